// File: rtl/bp_pkg.sv
// Shared types for the branch-prediction resolve queue: field widths,
// the buffered prediction entry and the controller state encoding.
package bp_pkg;

    localparam int PC_W  = 10;
    localparam int LHT_W = 10;
    localparam int PH_W  = 12;

    // One issued prediction waiting for its outcome
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [LHT_W-1:0] lht;
        logic             lp;
        logic             gp;
        logic             cp;
        logic [PH_W-1:0]  ph;
        logic             pred;
    } bp_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RECOVER = 2'd2
    } rq_state_e;

endpackage

// File: rtl/bp_entry_fifo.sv
// In-order storage for in-flight predictions. The head entry is presented
// combinationally; a flush empties the queue in one cycle.
module bp_entry_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_wr_en,
    input  bp_entry_t              i_wr_data,
    input  logic                   i_rd_en,
    output bp_entry_t              o_rd_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    bp_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    // Entry storage: payload only, never reset
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); count separates full from empty
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/bp_resolve_queue.sv
// Holds tournament-predictor predictions until their outcomes resolve in
// order, then emits one registered training packet per resolved branch.
// A mispredict repairs path history and flushes the wrong-path entries.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pred_valid,
    input  logic [PC_W-1:0]        PC,
    input  logic [LHT_W-1:0]       LHTresult,
    input  logic                   LPresult,
    input  logic                   GPresult,
    input  logic                   CPresult,
    input  logic [PH_W-1:0]        PHresult,
    input  logic                   PredictedBranch,
    input  logic                   resolve_valid,
    input  logic                   BranchTaken,
    output logic                   upd_valid,
    output logic [PC_W-1:0]        upd_PC,
    output logic [LHT_W-1:0]       upd_lht,
    output logic [PH_W-1:0]        upd_ph,
    output logic                   upd_taken,
    output logic                   upd_choice_valid,
    output logic                   upd_choice_dir,
    output logic                   mispredict,
    output logic                   ph_repair_valid,
    output logic [PH_W-1:0]        ph_repair,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       resolve_cnt,
    output logic [CNT_W-1:0]       mispredict_cnt,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rq_state_e  r_state;
    bp_entry_t  w_head;
    bp_entry_t  w_new;
    logic       w_push_req;
    logic       w_pop;
    logic       w_mis;
    logic       w_push;
    logic       w_unused_cp;

    assign w_new = '{pc: PC, lht: LHTresult, lp: LPresult, gp: GPresult,
                     cp: CPresult, ph: PHresult, pred: PredictedBranch};

    // Pushes are ignored for the single recovery cycle after a mispredict;
    // a mispredicting pop kills any same-cycle push as wrong-path.
    assign w_push_req = pred_valid && (r_state != RECOVER);
    assign w_pop      = resolve_valid && !empty;
    assign w_mis      = w_pop && (w_head.pred != BranchTaken);
    assign w_push     = w_push_req && !w_mis && (!full || w_pop);

    // Choice bit is carried for completeness; training only needs LP/GP
    assign w_unused_cp = w_head.cp;

    bp_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_flush   (w_mis),
        .i_wr_en   (w_push),
        .i_wr_data (w_new),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (count)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Controller: tracks occupancy phase and the one-cycle recovery window
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_push) r_state <= ACTIVE;
                ACTIVE: begin
                    if (w_mis)
                        r_state <= RECOVER;
                    else if (w_pop && !w_push && (count == CW'(1)))
                        r_state <= IDLE;
                end
                RECOVER: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Training-packet pulses, cleared on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            upd_valid        <= 1'b0;
            upd_choice_valid <= 1'b0;
            mispredict       <= 1'b0;
            ph_repair_valid  <= 1'b0;
        end else begin
            upd_valid        <= w_pop;
            upd_choice_valid <= w_pop && (w_head.lp != w_head.gp);
            mispredict       <= w_mis;
            ph_repair_valid  <= w_mis;
        end
    end

    // Training-packet payload, captured from the head on each pop
    always_ff @(posedge clock) begin
        if (w_pop) begin
            upd_PC         <= w_head.pc;
            upd_lht        <= w_head.lht;
            upd_ph         <= w_head.ph;
            upd_taken      <= BranchTaken;
            upd_choice_dir <= (w_head.gp == BranchTaken);
            ph_repair      <= {w_head.ph[PH_W-2:0], BranchTaken};
        end
    end

    // Saturating statistics and sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            resolve_cnt    <= '0;
            mispredict_cnt <= '0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            if (w_pop) resolve_cnt    <= sat_inc(resolve_cnt);
            if (w_mis) mispredict_cnt <= sat_inc(mispredict_cnt);
            if (w_push_req && full && !w_pop) overflow_err  <= 1'b1;
            if (resolve_valid && empty)       underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed and randomized bench for bp_resolve_queue against a queue-based
// reference model of the in-order resolve behaviour.
module tb_bp_resolve_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [9:0]  PC;
    logic [9:0]  LHTresult;
    logic        LPresult, GPresult, CPresult;
    logic [11:0] PHresult;
    logic        PredictedBranch;
    logic        resolve_valid;
    logic        BranchTaken;
    logic        upd_valid;
    logic [9:0]  upd_PC;
    logic [9:0]  upd_lht;
    logic [11:0] upd_ph;
    logic        upd_taken, upd_choice_valid, upd_choice_dir;
    logic        mispredict, ph_repair_valid;
    logic [11:0] ph_repair;
    logic        full, empty;
    logic [2:0]  count;
    logic [CNT_W-1:0] resolve_cnt, mispredict_cnt;
    logic        overflow_err, underflow_err;

    bp_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .pred_valid(pred_valid), .PC(PC),
        .LHTresult(LHTresult), .LPresult(LPresult), .GPresult(GPresult),
        .CPresult(CPresult), .PHresult(PHresult), .PredictedBranch(PredictedBranch),
        .resolve_valid(resolve_valid), .BranchTaken(BranchTaken),
        .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_lht(upd_lht), .upd_ph(upd_ph),
        .upd_taken(upd_taken), .upd_choice_valid(upd_choice_valid),
        .upd_choice_dir(upd_choice_dir), .mispredict(mispredict),
        .ph_repair_valid(ph_repair_valid), .ph_repair(ph_repair),
        .full(full), .empty(empty), .count(count),
        .resolve_cnt(resolve_cnt), .mispredict_cnt(mispredict_cnt),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  pc;
        logic [9:0]  lht;
        logic        lp;
        logic        gp;
        logic [11:0] ph;
        logic        pred;
    } ent_t;

    ent_t q[$];
    bit   m_rec;
    int   m_rc, m_mc;
    bit   m_ovf, m_udf;
    bit   e_uv, e_mis, e_cv, e_cd, e_tk;
    logic [9:0]  e_pc, e_lht;
    logic [11:0] e_ph, e_rep;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict from the current inputs, then compare after the edge
    task automatic step();
        ent_t h;
        ent_t n;
        bit   pop;
        bit   mis;
        pop = 1'b0;
        mis = 1'b0;
        if (reset) begin
            q.delete();
            m_rec = 0; m_rc = 0; m_mc = 0; m_ovf = 0; m_udf = 0;
            e_uv = 0; e_mis = 0; e_cv = 0;
        end else begin
            pop = resolve_valid && (q.size() > 0);
            if (pop) mis = (q[0].pred != BranchTaken);
            e_uv = pop; e_mis = mis; e_cv = 0;
            if (resolve_valid && q.size() == 0) m_udf = 1;
            if (pop) begin
                h = q.pop_front();
                e_pc = h.pc; e_lht = h.lht; e_ph = h.ph; e_tk = BranchTaken;
                e_cv = (h.lp != h.gp);
                e_cd = (h.gp == BranchTaken);
                e_rep = {h.ph[10:0], BranchTaken};
                if (m_rc < CMAX) m_rc++;
                if (mis && m_mc < CMAX) m_mc++;
            end
            if (mis) begin
                q.delete();
            end else if (pred_valid && !m_rec) begin
                if (q.size() < DEPTH) begin
                    n.pc = PC; n.lht = LHTresult; n.lp = LPresult; n.gp = GPresult;
                    n.ph = PHresult; n.pred = PredictedBranch;
                    q.push_back(n);
                end else begin
                    m_ovf = 1;
                end
            end
            m_rec = mis;
        end
        @(posedge clock);
        #1;
        chk("upd_valid", 32'(upd_valid), 32'(e_uv));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        chk("ph_repair_valid", 32'(ph_repair_valid), 32'(e_mis));
        chk("upd_choice_valid", 32'(upd_choice_valid), 32'(e_cv));
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("resolve_cnt", 32'(resolve_cnt), 32'(m_rc));
        chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mc));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("underflow_err", 32'(underflow_err), 32'(m_udf));
        if (e_uv) begin
            chk("upd_PC", 32'(upd_PC), 32'(e_pc));
            chk("upd_lht", 32'(upd_lht), 32'(e_lht));
            chk("upd_ph", 32'(upd_ph), 32'(e_ph));
            chk("upd_taken", 32'(upd_taken), 32'(e_tk));
            chk("upd_choice_dir", 32'(upd_choice_dir), 32'(e_cd));
        end
        if (e_mis) chk("ph_repair", 32'(ph_repair), 32'(e_rep));
    endtask

    task automatic drive(input bit pv, input logic [9:0] pc, input logic [11:0] ph,
                         input bit lp, input bit gp, input bit pred,
                         input bit rv, input bit tk);
        pred_valid      = pv;
        PC              = pc;
        LHTresult       = {pc[4:0], pc[9:5]};
        LPresult        = lp;
        GPresult        = gp;
        CPresult        = ~lp;
        PHresult        = ph;
        PredictedBranch = pred;
        resolve_valid   = rv;
        BranchTaken     = tk;
    endtask

    task automatic idle();
        drive(0, 10'h0, 12'h0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        reset = 1'b0;

        // 1: correct prediction trains without mispredict
        drive(1, 10'h05A, 12'h123, 1, 1, 1, 0, 0); step();
        drive(0, 10'h0, 12'h0, 0, 0, 0, 1, 1);     step();
        chk("t1_upd_PC", 32'(upd_PC), 32'h05A);
        chk("t1_mispredict", 32'(mispredict), 32'd0);

        // 2: mispredict repairs path history and opens a recovery cycle
        drive(1, 10'h111, 12'hABC, 0, 0, 0, 0, 0); step();
        drive(1, 10'h222, 12'h001, 0, 0, 0, 0, 0); step();
        drive(0, 10'h0, 12'h0, 0, 0, 0, 1, 1);     step();
        chk("t2_ph_repair", 32'(ph_repair), 32'h579);
        chk("t2_count", 32'(count), 32'd0);
        drive(1, 10'h333, 12'h002, 0, 0, 1, 0, 0); step();
        chk("t2_recover_push", 32'(count), 32'd0);
        drive(1, 10'h334, 12'h003, 0, 0, 1, 0, 0); step();
        drive(0, 10'h0, 12'h0, 0, 0, 0, 1, 1);     step();

        // 3: fill, overflow, then push+pop while full
        for (int i = 0; i < 4; i++) begin
            drive(1, 10'(i + 16), 12'(i * 7), 0, 1, 1, 0, 0); step();
        end
        drive(1, 10'h3FF, 12'hFFF, 0, 0, 1, 0, 0); step();
        chk("t3_overflow", 32'(overflow_err), 32'd1);
        drive(1, 10'h2AA, 12'h555, 1, 1, 1, 1, 1); step();
        chk("t3_full_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 10'h0, 12'h0, 0, 0, 0, 1, 1); step();
        end

        // 4: choice training only when LP and GP disagree
        drive(1, 10'h040, 12'h040, 1, 0, 0, 0, 0); step();
        drive(0, 10'h0, 12'h0, 0, 0, 0, 1, 0);     step();
        chk("t4_cv", 32'(upd_choice_valid), 32'd1);
        chk("t4_cd", 32'(upd_choice_dir), 32'd1);
        drive(1, 10'h041, 12'h041, 1, 1, 1, 0, 0); step();
        drive(0, 10'h0, 12'h0, 0, 0, 0, 1, 1);     step();
        chk("t4_cv_same", 32'(upd_choice_valid), 32'd0);

        // 5: underflow, then reset with entries held
        drive(0, 10'h0, 12'h0, 0, 0, 0, 1, 1); step();
        chk("t5_underflow", 32'(underflow_err), 32'd1);
        chk("t5_no_upd", 32'(upd_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 10'(i + 100), 12'(i), 0, 0, 1, 0, 0); step();
        end
        idle();
        reset = 1'b1; step();
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_flags", 32'({overflow_err, underflow_err}), 32'd0);
        reset = 1'b0; step();
        chk("t5_rst_no_upd", 32'(upd_valid), 32'd0);

        // 6: mispredicting pop with a same-cycle push drops the push quietly
        drive(1, 10'h060, 12'h060, 0, 0, 1, 0, 0); step();
        drive(1, 10'h061, 12'h061, 0, 0, 1, 1, 0); step();
        chk("t6_mis", 32'(mispredict), 32'd1);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_ovf", 32'(overflow_err), 32'd0);
        chk("t6_mcnt", 32'(mispredict_cnt), 32'd1);

        // Randomized traffic, including rare resets and counter saturation
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 79) == 0);
            pred_valid      = ($urandom_range(0, 9) < 6);
            PC              = 10'($urandom);
            LHTresult       = 10'($urandom);
            LPresult        = 1'($urandom);
            GPresult        = 1'($urandom);
            CPresult        = 1'($urandom);
            PHresult        = 12'($urandom);
            PredictedBranch = 1'($urandom);
            resolve_valid   = ($urandom_range(0, 9) < 5);
            BranchTaken     = ($urandom_range(0, 9) < 8) ? PredictedBranch : ~PredictedBranch;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
